reg_pipe_n: RTL

//  - Parametrised N-stage, W-bit registered delay line with a valid bit per stage.
//  - Per-cycle advance enable and a synchronous clear (force_0).
//  - Used wherever game-logic signals (positions, hit flags, colour words) must be

---
 rtl/reg_pipe_pkg.sv | 9 +
 rtl/reg_pipe_stage.sv | 31 +++
 rtl/reg_pipe_n.sv | 82 ++++++++
 3 files changed

// File: rtl/reg_pipe_pkg.sv
// Shared definitions for the reg_pipe_n delay line.
package reg_pipe_pkg;

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One stage of the registered delay line: a WIDTH-bit register with
// synchronous active-low reset, advance enable and synchronous clear.
// Priority: reset_n=0 > i_enable=1 > i_force_0=1 > hold.
module reg_pipe_stage #(
    parameter int unsigned         WIDTH     = 9,
    parameter logic [WIDTH-1:0]    CLR_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_enable,
    input  logic             i_force_0,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Stage register: reset, advance, clear or hold.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_q <= CLR_VALUE;
        end else if (i_enable) begin
            r_q <= i_d;
        end else if (i_force_0) begin
            r_q <= CLR_VALUE;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/reg_pipe_n.sv
// N-stage, W-bit registered delay line with a valid bit per stage,
// advance enable and synchronous clear (force_0, ignored while enable=1).
// Optional feature: define REG_PIPE_OCC_EN to build the registered
// occupancy counter and its output port.
module reg_pipe_n
    import reg_pipe_pkg::*;
#(
    parameter int unsigned         WIDTH     = 8,
    parameter int unsigned         DEPTH     = 4,
    parameter logic [WIDTH-1:0]    CLR_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             force_0,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             out_valid
`ifdef REG_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

    // Stage record: valid flag above the data word.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t w_stage_d [DEPTH];
    stage_t w_stage_q [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_stage_d[g] = '{valid: in_valid, data: d_in};
        end else begin : g_body
            assign w_stage_d[g] = w_stage_q[g-1];
        end

        reg_pipe_stage #(
            .WIDTH     (WIDTH + 1),
            .CLR_VALUE ({1'b0, CLR_VALUE})
        ) u_stage (
            .clock     (clock),
            .reset_n   (reset_n),
            .i_enable  (enable),
            .i_force_0 (force_0),
            .i_d       (w_stage_d[g]),
            .o_q       (w_stage_q[g])
        );
    end

    // Outputs come straight from the last stage flops.
    assign d_out     = w_stage_q[DEPTH-1].data;
    assign out_valid = w_stage_q[DEPTH-1].valid;

`ifdef REG_PIPE_OCC_EN
    localparam int unsigned OCC_W = occ_width(DEPTH);

    logic [OCC_W-1:0] r_occ;
    logic [OCC_W-1:0] w_occ_next;

    // Entry in and entry out on the same advance cancel out.
    assign w_occ_next = r_occ + OCC_W'(in_valid) - OCC_W'(out_valid);

    // Occupancy counter tracks the number of valid stages.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_occ <= '0;
        end else if (enable) begin
            r_occ <= w_occ_next;
        end else if (force_0) begin
            r_occ <= '0;
        end
    end

    assign occupancy = r_occ;
`endif

endmodule
